wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

- Shares the register-file write port between two requesters:
  - the in-order write-back stage (pipeline requester);
  - a long-latency unit (multiplier/divider) that returns results out of band.
- Long-latency results are buffered in a small FIFO and merged into spare write-port cycles.
- A starvation counter forces a buffered write through, stalling the pipeline for one cycle.
- Sits between the write-back stage and the decoder's register bank; its registered outputs drive the bank's write port.

## Interface

Parameters:

- DEPTH, 2: FIFO entries for long-latency results (power of two, ≥2).
- MAX_WAIT, 4: consecutive cycles a non-empty FIFO may be denied before a forced grant (1–15).

Ports:

- Clocking and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pipe_write_reg  in  1  write-back stage requests a register write this cycle.
- pipe_rd  in  5  destination register of the pipeline write.
- pipe_data  in  32  pipeline write data.
- pipe_stall  out  1  combinational; pipeline must hold its write-back inputs this cycle.
- lu_valid  in  1  long-latency unit offers a result.
- lu_rd  in  5  destination register of the offered result.
- lu_data  in  32  offered result data.
- lu_ready  out  1  FIFO can accept; registered (not full).
- rf_we  out  1  registered write enable to the register bank.
- rf_rd  out  5  registered write address.
- rf_wdata  out  32  registered write data.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation

- **Effective requests**
  - Pipeline request: pipe_req = pipe_write_reg && pipe_rd != 0.
  - A pipeline write to x0 never uses the port and never stalls.
  - FIFO request: fifo_req = fifo_count != 0.
- **Grant decision** (combinational, each cycle):
  - force = fifo_req && wait_cnt == MAX_WAIT.
  - FIFO is granted if fifo_req && (!pipe_req || force).
  - Otherwise the pipeline is granted if pipe_req.
  - Otherwise there is no grant.
- **Stall**
  - pipe_stall = pipe_req && FIFO granted.
  - pipe_stall is 1 only on forced grants: with fifo_req, the FIFO wins without stalling only when pipe_req = 0.
- **wait_cnt** (internal, 4 bits):
  - Cleared when the FIFO is empty or the FIFO is granted.
  - Otherwise, while fifo_req && pipeline granted, increments, saturating at MAX_WAIT.
- **Push**
  - Fires when lu_valid && lu_ready.
  - A result with lu_rd == 0 is accepted (handshake completes) but is not stored.
- **Pop**: the FIFO head is removed in the same cycle it is granted.
- **Write-port register**: on a grant, rf_we ← 1 and rf_rd/rf_wdata ← the winner's values. With no grant, rf_we ← 0 and rf_rd/rf_wdata hold their last values.
- **Ordering**: RAW/WAW ordering between the two requesters is not checked here. The issue scoreboard guarantees that no pipeline write targets an rd with an outstanding long-latency result.

## Timing

- **Reset**:
  - While rst = 1: rf_we = 0, rf_rd = 0, rf_wdata = 0, fifo_count = 0, wait_cnt = 0, lu_ready = 0, pipe_stall = 0 (forced low).
  - lu_ready rises to 1 on the first clock after rst deasserts.
  - Reset mid-operation discards all FIFO contents.
- **Latency**: grant in cycle N → rf_we/rf_rd/rf_wdata valid in cycle N+1.
  - A pushed result is granted no earlier than the cycle after its push (FIFO is not bypassed), so push-to-rf_we latency is ≥2 cycles.
- **lu_ready** = (fifo_count < DEPTH), registered from the post-update count.
  - A push in the same cycle as a pop while full is impossible: ready is already 0.
- **Simultaneous push and pop** (not full): count is unchanged, and the head advances correctly.
  - With DEPTH entries, pointer wrap-around is modulo DEPTH.
- **Forced grant** occurs on the cycle where wait_cnt == MAX_WAIT, i.e. after MAX_WAIT consecutive denied cycles.
  - With continuous pipe_req and a non-empty FIFO, the pipeline stalls exactly 1 of every MAX_WAIT+1 cycles.
- **pipe_stall** depends only on current inputs and registered state; there is no combinational path from lu_valid.

## Test plan

- **Reset**: hold rst for 3 cycles with all inputs active → all outputs 0, lu_ready 0. Release → lu_ready = 1 in the next cycle, fifo_count = 0.
- **Idle merge**: pipe_write_reg = 0; push lu_rd = 5, lu_data = 0xDEADBEEF at cycle N → rf_we = 1, rf_rd = 5, rf_wdata = 0xDEADBEEF at cycle N+2. fifo_count returns to 0 and pipe_stall stays 0.
- **Starvation (MAX_WAIT = 4)**:
  - Setup: pipe_write_reg = 1 continuously with pipe_rd = 1..; one buffered result with rd = 9.
  - Expected: four pipeline writes, then pipe_stall = 1 for exactly one cycle and rf_rd = 9 in the following cycle. After that, pipeline writes resume with no data lost.
- **Full FIFO (DEPTH = 2)**: push 2 results while the pipeline writes every cycle → fifo_count = 2 and lu_ready = 0. A third lu_valid is held until a forced pop, then accepted; results reach rf in push order.
- **x0 handling**:
  - pipe_rd = 0 with pipe_write_reg = 1 → no rf_we, and a buffered entry is granted without a stall.
  - lu_rd = 0 push → handshake completes and fifo_count is unchanged.
- **Reset mid-operation**: FIFO holding 2 entries, assert rst for 1 cycle → fifo_count = 0, and no stale rf_we appears afterward.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter merging long-latency results into spare cycles
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_write_reg,
  input  logic [4:0]                 pipe_rd,
  input  logic [31:0]                pipe_data,
  output logic                       pipe_stall,
  input  logic                       lu_valid,
  input  logic [4:0]                 lu_rd,
  input  logic [31:0]                lu_data,
  output logic                       lu_ready,
  output logic                       rf_we,
  output logic [4:0]                 rf_rd,
  output logic [31:0]                rf_wdata,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    mem_rd   [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [3:0]    wait_cnt;

  logic          pipe_req;
  logic          fifo_req;
  logic          force_grant;
  logic          fifo_grant;
  logic          pipe_grant;
  logic          push;
  logic          store;
  logic [CW-1:0] count_next;

  always_comb begin
    pipe_req    = pipe_write_reg && (pipe_rd != 5'd0);
    fifo_req    = (fifo_count != '0);
    force_grant = fifo_req && (wait_cnt == 4'(MAX_WAIT));
    fifo_grant  = fifo_req && (!pipe_req || force_grant);
    pipe_grant  = !fifo_grant && pipe_req;
    // Results for x0 complete the handshake but are dropped here.
    push        = lu_valid && lu_ready;
    store       = push && (lu_rd != 5'd0);
    count_next  = fifo_count + CW'(store) - CW'(fifo_grant);
    pipe_stall  = !rst && pipe_req && fifo_grant;
  end

  always_ff @(posedge clk) begin
    if (store) begin
      mem_rd[wr_ptr]   <= lu_rd;
      mem_data[wr_ptr] <= lu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      lu_ready   <= 1'b0;
      wait_cnt   <= 4'd0;
      rf_we      <= 1'b0;
      rf_rd      <= 5'd0;
      rf_wdata   <= 32'd0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_grant) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= count_next;
      lu_ready   <= (count_next < CW'(DEPTH));

      if (!fifo_req || fifo_grant) begin
        wait_cnt <= 4'd0;
      end else if (pipe_grant && (wait_cnt != 4'(MAX_WAIT))) begin
        wait_cnt <= wait_cnt + 4'd1;
      end

      // Address and data hold on idle cycles; only the enable drops.
      rf_we <= fifo_grant || pipe_grant;
      if (fifo_grant) begin
        rf_rd    <= mem_rd[rd_ptr];
        rf_wdata <= mem_data[rd_ptr];
      end else if (pipe_grant) begin
        rf_rd    <= pipe_rd;
        rf_wdata <= pipe_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter (DEPTH=2, MAX_WAIT=4)
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_write_reg;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [1:0]  fifo_count;

  wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_write_reg(pipe_write_reg), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .pipe_stall(pipe_stall),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        rst;
    logic        pwr;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        e_stall;
    logic [1:0]  e_count;
    logic        e_ready;
    logic        e_we;
    logic        sb_v;
    logic [4:0]  sb_rd;
    logic [31:0] sb_data;
  } vec_t;

  wr_t  sb_q[$];
  wr_t  lu_q[$];
  wr_t  pend_q[$];
  vec_t tbl[14];
  int   errors = 0;
  int   checks = 0;
  logic [4:0] cur_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every rf write must match the next expected write, in order.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got rf_we rd=%0d data=%0h expected no write at %0t", rf_rd, rf_wdata, $time);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("sb_rd", 32'(rf_rd), 32'(e.rd));
        chk("sb_data", rf_wdata, e.data);
      end
    end
  end

  task automatic idle_inputs();
    pipe_write_reg = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
    lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
  endtask

  // Pipeline writes every cycle; lu_q items are offered in order. Stalls are expected on stall_mask bits.
  task automatic run_seq(input int n, input logic [31:0] stall_mask);
    for (int i = 0; i < n; i++) begin
      rst = 1'b0;
      pipe_write_reg = 1'b1;
      pipe_rd = cur_rd;
      pipe_data = 32'hA000_0000 | 32'(cur_rd);
      if (lu_q.size() > 0) begin
        lu_valid = 1'b1; lu_rd = lu_q[0].rd; lu_data = lu_q[0].data;
      end else begin
        lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
      end
      #3;
      chk("seq_count", 32'(fifo_count), 32'(pend_q.size()));
      chk("seq_ready", 32'(lu_ready), 32'(pend_q.size() < 2));
      chk("seq_stall", 32'(pipe_stall), 32'(stall_mask[i]));
      if (stall_mask[i]) begin
        if (pend_q.size() > 0) sb_q.push_back(pend_q.pop_front());
      end else begin
        sb_q.push_back('{rd: cur_rd, data: pipe_data});
        cur_rd = (cur_rd == 5'd31) ? 5'd1 : cur_rd + 5'd1;
      end
      if (lu_valid && lu_ready) begin
        if (lu_rd != 5'd0) pend_q.push_back(lu_q[0]);
        void'(lu_q.pop_front());
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    tbl[0]  = '{1,1,3,32'h33,1,4,32'h44,        0,0,0,0, 0,0,32'h0};
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = '{0,0,0,32'h0,0,0,32'h0,          0,0,0,0, 0,0,32'h0};
    tbl[4]  = '{0,0,0,32'h0,1,5,32'hDEADBEEF,   0,0,1,0, 1,5,32'hDEADBEEF};
    tbl[5]  = '{0,0,0,32'h0,0,0,32'h0,          0,1,1,0, 0,0,32'h0};
    tbl[6]  = '{0,0,0,32'h0,0,0,32'h0,          0,0,1,1, 0,0,32'h0};
    tbl[7]  = '{0,1,0,32'h1111,1,7,32'hA7,      0,0,1,0, 1,7,32'hA7};
    tbl[8]  = '{0,1,0,32'h1111,0,0,32'h0,       0,1,1,0, 0,0,32'h0};
    tbl[9]  = '{0,1,0,32'h1111,1,0,32'hBAD,     0,0,1,1, 0,0,32'h0};
    tbl[10] = '{0,0,0,32'h0,0,0,32'h0,          0,0,1,0, 0,0,32'h0};
    tbl[11] = '{0,1,12,32'hC12,0,0,32'h0,       0,0,1,0, 1,12,32'hC12};
    tbl[12] = '{0,0,0,32'h0,0,0,32'h0,          0,0,1,1, 0,0,32'h0};
    tbl[13] = '{0,0,0,32'h0,0,0,32'h0,          0,0,1,0, 0,0,32'h0};

    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;

    // Reset, idle merge and x0 handling, cycle by cycle.
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst;
      pipe_write_reg = tbl[i].pwr; pipe_rd = tbl[i].prd; pipe_data = tbl[i].pdata;
      lu_valid = tbl[i].lv; lu_rd = tbl[i].lrd; lu_data = tbl[i].ldata;
      if (tbl[i].sb_v) sb_q.push_back('{rd: tbl[i].sb_rd, data: tbl[i].sb_data});
      #3;
      chk($sformatf("tbl%0d_stall", i), 32'(pipe_stall), 32'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_count", i), 32'(fifo_count), 32'(tbl[i].e_count));
      chk($sformatf("tbl%0d_ready", i), 32'(lu_ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_we", i), 32'(rf_we), 32'(tbl[i].e_we));
      if (tbl[i].rst) begin
        chk($sformatf("tbl%0d_rd0", i), 32'(rf_rd), 32'd0);
        chk($sformatf("tbl%0d_wdata0", i), rf_wdata, 32'd0);
      end
      @(posedge clk); #1;
    end

    // Starvation: one buffered rd=9 result against continuous pipeline writes.
    cur_rd = 5'd1;
    lu_q.push_back('{rd: 5'd9, data: 32'h9999_0009});
    run_seq(7, 32'h0000_0020);

    // Full FIFO: third result is held until the first forced pop frees a slot.
    lu_q.push_back('{rd: 5'd20, data: 32'h2020_0020});
    lu_q.push_back('{rd: 5'd21, data: 32'h2121_0021});
    lu_q.push_back('{rd: 5'd22, data: 32'h2222_0022});
    run_seq(17, (32'd1 << 5) | (32'd1 << 10) | (32'd1 << 15));
    chk("full_lu_drained", 32'(lu_q.size()), 32'd0);

    // Reset with two buffered entries: contents must be discarded.
    lu_q.push_back('{rd: 5'd25, data: 32'h2525_0025});
    lu_q.push_back('{rd: 5'd26, data: 32'h2626_0026});
    run_seq(2, 32'h0);
    rst = 1'b1;
    pipe_write_reg = 1'b1; pipe_rd = cur_rd; pipe_data = 32'hBEEF_0000;
    lu_valid = 1'b1; lu_rd = 5'd27; lu_data = 32'h2727_0027;
    #3;
    chk("mid_rst_count_before", 32'(fifo_count), 32'd2);
    chk("mid_rst_stall", 32'(pipe_stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    pend_q.delete();
    lu_q.delete();
    #3;
    chk("post_rst_count", 32'(fifo_count), 32'd0);
    chk("post_rst_ready", 32'(lu_ready), 32'd0);
    chk("post_rst_we", 32'(rf_we), 32'd0);
    chk("post_rst_rd", 32'(rf_rd), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("post_rst_idle_count", 32'(fifo_count), 32'd0);
      chk("post_rst_idle_ready", 32'(lu_ready), 32'd1);
      chk("post_rst_idle_we", 32'(rf_we), 32'd0);
      @(posedge clk); #1;
    end

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
